// File: rtl/video_pkg.sv
// Shared types, default 640x480@60 timing and the sync polarity helper for
// the video timing output path.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Convert an active-high raw sync into the pin level.
  function automatic logic sync_level(input logic raw, input logic active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster counters with position decode.
// Ports:
//   clk, rst       pixel clock, synchronous active-high reset
//   en             0 = hold counters at 0,0
//   active         current position is inside active video
//   hsync_raw      active-high hsync for the current position
//   vsync_raw      active-high vsync for the current position
//   frame_start    position h=0, v=V_ACTIVE (first cycle of vertical blank)
module raster_counter import video_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic frame_start
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_raw   = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vsync_raw   = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == V_ACT);

endmodule

// File: rtl/video_timing_output.sv
// Raster timing generator and pixel sink feeding a display PHY.
// Pulls one pixel per active cycle from pixel_generator, registers RGB/DE/
// syncs together (1-cycle latency) and strobes out_next_frame at the start
// of vertical blank. Underflow (no valid pixel in active video) outputs
// black with DE high and sets a sticky flag.
// Ports:
//   in_clk, in_reset         pixel clock, synchronous active-high reset
//   in_enable                0 = raster held at origin, outputs idle
//   in_pixel_data/valid      upstream RGB888 stream
//   in_pixel_ready           accept strobe (combinational from counters)
//   in_clear_underflow       clears sticky flag and counter
//   out_next_frame           one-cycle frame-restart strobe
//   out_rgb/de/hsync/vsync   registered display outputs
//   out_underflow            sticky underflow flag
//   out_underflow_count      saturating underflow pixel count
// Build option: VIDEO_UNDERFLOW_COUNT_EN builds the underflow counter;
// otherwise out_underflow_count is tied to 0.
module video_timing_output import video_pkg::*; #(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        in_clk,
  input  logic        in_reset,
  input  logic        in_enable,
  input  logic [23:0] in_pixel_data,
  input  logic        in_pixel_valid,
  output logic        in_pixel_ready,
  input  logic        in_clear_underflow,
  output logic        out_next_frame,
  output logic [23:0] out_rgb,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_underflow,
  output logic [15:0] out_underflow_count
);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_params
    $error("video_timing_output: all timing parameters must be >= 1");
  end

  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic active, hsync_raw, vsync_raw, frame_start;

  raster_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_raster (
    .clk        (in_clk),
    .rst        (in_reset),
    .en         (in_enable),
    .active     (active),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .frame_start(frame_start)
  );

  rgb888_t rgb_q, rgb_d;
  logic    de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic    next_frame_q, next_frame_d, underflow_q, underflow_d;
  logic    uf_event;

  assign uf_event       = in_enable && active && !in_pixel_valid;
  assign in_pixel_ready = active && in_enable && !in_reset;

  always_comb begin
    rgb_d        = '0;
    de_d         = 1'b0;
    hsync_d      = SYNC_IDLE;
    vsync_d      = SYNC_IDLE;
    next_frame_d = 1'b0;
    if (in_enable) begin
      de_d         = active;
      if (active && in_pixel_valid) rgb_d = rgb888_t'(in_pixel_data);
      hsync_d      = sync_level(hsync_raw, SYNC_ACTIVE_LOW);
      vsync_d      = sync_level(vsync_raw, SYNC_ACTIVE_LOW);
      next_frame_d = frame_start;
    end
    // Set wins over a same-cycle clear.
    underflow_d = uf_event ? 1'b1 : (in_clear_underflow ? 1'b0 : underflow_q);
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      rgb_q        <= '0;
      de_q         <= 1'b0;
      hsync_q      <= SYNC_IDLE;
      vsync_q      <= SYNC_IDLE;
      next_frame_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      de_q         <= de_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      next_frame_q <= next_frame_d;
      underflow_q  <= underflow_d;
    end
  end

`ifdef VIDEO_UNDERFLOW_COUNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (in_clear_underflow)                  uf_cnt_d = uf_event ? 16'd1 : 16'd0;
    else if (uf_event && uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) uf_cnt_q <= '0;
    else          uf_cnt_q <= uf_cnt_d;
  end

  assign out_underflow_count = uf_cnt_q;
`else
  assign out_underflow_count = '0;
`endif

  assign out_rgb        = rgb_q;
  assign out_de         = de_q;
  assign out_hsync      = hsync_q;
  assign out_vsync      = vsync_q;
  assign out_next_frame = next_frame_q;
  assign out_underflow  = underflow_q;

endmodule

// File: tb/tb_video_timing_output.sv
// Bench for video_timing_output with an 8x6 raster (4/1/2/1, 3/1/1/1).
// The reference model tracks the raster as a single linear frame position
// (0..47) and derives h/v with div/mod.
module tb_video_timing_output;

  localparam int HT = 8, VT = 6, FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst, en, valid, clr;
  logic [23:0] data;
  logic        ready, nf, de, hs, vs, uf;
  logic [23:0] rgb;
  logic [15:0] ucnt;

  video_timing_output #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .in_clk(clk), .in_reset(rst), .in_enable(en),
    .in_pixel_data(data), .in_pixel_valid(valid), .in_pixel_ready(ready),
    .in_clear_underflow(clr), .out_next_frame(nf), .out_rgb(rgb),
    .out_de(de), .out_hsync(hs), .out_vsync(vs),
    .out_underflow(uf), .out_underflow_count(ucnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic [23:0] rgb;
    logic        de, hs, vs, nf, uf;
    logic [15:0] cnt;
  } exp_t;

  int tests = 0, fails = 0;
  int m_pos = 0;
  bit m_uf = 0;
  int m_cnt = 0;
  bit inc_mode = 1;

  // Expected ready for this cycle and expected outputs after the next edge.
  function automatic exp_t model_step();
    exp_t e;
    int h, v;
    bit act, uev;
    h = m_pos % HT;
    v = m_pos / HT;
    act = (h < 4) && (v < 3);
    e = '0;
    e.ready = !rst && en && act;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (rst) begin
      m_pos = 0; m_uf = 0; m_cnt = 0;
    end else begin
      uev = en && act && !valid;
      if (en) begin
        e.de  = act;
        e.rgb = (act && valid) ? data : 24'h0;
        e.hs  = !(h == 5 || h == 6);
        e.vs  = !(v == 4);
        e.nf  = (h == 0 && v == 3);
        m_pos = (m_pos + 1) % FT;
      end else begin
        m_pos = 0;
      end
      if (uev) m_uf = 1;
      else if (clr) m_uf = 0;
`ifdef VIDEO_UNDERFLOW_COUNT_EN
      if (clr) m_cnt = uev ? 1 : 0;
      else if (uev && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
    end
    e.uf  = m_uf;
    e.cnt = 16'(m_cnt);
    return e;
  endfunction

  // One clock: sample ready before the edge, step the model, advance the
  // upstream source on a handshake.
  task automatic tick(output exp_t e, output logic rdy);
    #2;
    rdy = ready;
    e = model_step();
    @(posedge clk);
    #1;
    if (e.ready && valid) data = inc_mode ? data + 24'd1 : 24'($urandom);
  endtask

  task automatic run_to(input int p);
    exp_t e; logic r;
    for (int i = 0; i < 100 && m_pos != p; i++) tick(e, r);
  endtask

  function automatic logic [45:0] obs(input logic r);
    return {r, rgb, de, hs, vs, nf, uf, ucnt};
  endfunction

  task automatic test_reset();
    exp_t e; logic r;
    rst = 1; en = 1; valid = 1; clr = 0; data = 24'h1;
    tick(e, r);
    tick(e, r);
    tests++;
    if (obs(r) !== {1'b0, 24'h0, 5'b01100, 16'h0}) begin
      fails++; $display("FAIL reset_values: got %h want %h", obs(r), {1'b0, 24'h0, 5'b01100, 16'h0});
    end
    tests++;
    if (obs(r) !== e) begin fails++; $display("FAIL reset_model: got %h want %h", obs(r), e); end
  endtask

  task automatic test_stream();
    exp_t e; logic r;
    int n_hs = 0, n_de = 0, bad = 0;
    logic [23:0] nxt = 24'h1;
    rst = 0; en = 1; valid = 1; inc_mode = 1; data = 24'h1;
    for (int i = 0; i < FT; i++) begin
      tick(e, r);
      if (obs(r) !== e) begin
        bad++; $display("FAIL stream_cycle%0d: got %h want %h", i, obs(r), e);
      end
      if (r) begin
        if (rgb !== nxt) begin bad++; $display("FAIL stream_rgb: got %h want %h", rgb, nxt); end
        nxt++;
        n_hs++;
      end
      if (de) n_de++;
    end
    tests++; if (bad != 0) fails++;
    tests++; if (n_hs != 12) begin fails++; $display("FAIL stream_handshakes: got %0d want 12", n_hs); end
    tests++; if (n_de != 12) begin fails++; $display("FAIL stream_de_count: got %0d want 12", n_de); end
  endtask

  task automatic test_sync();
    exp_t e; logic r;
    int n_nf = 0, n_vs = 0, n_hs = 0, bad = 0;
    for (int i = 0; i < FT; i++) begin
      tick(e, r);
      if ({hs, vs, nf} !== {e.hs, e.vs, e.nf}) begin
        bad++; $display("FAIL sync_cycle%0d: got %b want %b", i, {hs, vs, nf}, {e.hs, e.vs, e.nf});
      end
      if (nf) n_nf++;
      if (!vs) n_vs++;
      if (!hs) n_hs++;
    end
    tests++; if (bad != 0) fails++;
    tests++; if (n_nf != 1) begin fails++; $display("FAIL sync_next_frame: got %0d want 1", n_nf); end
    tests++; if (n_vs != 8) begin fails++; $display("FAIL sync_vsync_low: got %0d want 8", n_vs); end
    tests++; if (n_hs != 12) begin fails++; $display("FAIL sync_hsync_low: got %0d want 12", n_hs); end
  endtask

  task automatic test_underflow();
    exp_t e; logic r;
    logic [15:0] want_cnt;
`ifdef VIDEO_UNDERFLOW_COUNT_EN
    want_cnt = 16'd2;
`else
    want_cnt = 16'd0;
`endif
    valid = 1;
    run_to(9);
    valid = 0;
    for (int i = 0; i < 2; i++) begin
      tick(e, r);
      tests++;
      if ({rgb, de} !== {24'h0, 1'b1} || obs(r) !== e) begin
        fails++; $display("FAIL underflow_out%0d: got %h want %h", i, obs(r), e);
      end
    end
    valid = 1;
    tick(e, r);
    tests++;
    if ({uf, ucnt} !== {1'b1, want_cnt}) begin
      fails++; $display("FAIL underflow_flag: got %b/%0d want 1/%0d", uf, ucnt, want_cnt);
    end
    clr = 1;
    tick(e, r);
    clr = 0;
    tests++;
    if ({uf, ucnt} !== 17'h0) begin
      fails++; $display("FAIL underflow_clear: got %b/%0d want 0/0", uf, ucnt);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic r;
    valid = 1;
    run_to(10);
    rst = 1;
    tick(e, r);
    rst = 0;
    tests++;
    if (obs(r) !== {1'b0, 24'h0, 5'b01100, 16'h0}) begin
      fails++; $display("FAIL reset_mid_values: got %h want %h", obs(r), {1'b0, 24'h0, 5'b01100, 16'h0});
    end
    tick(e, r);
    tests++;
    if (r !== 1'b1 || de !== 1'b1 || obs(r) !== e) begin
      fails++; $display("FAIL reset_mid_restart: got %h want %h", obs(r), e);
    end
  endtask

  task automatic test_enable();
    exp_t e; logic r;
    int bad = 0;
    valid = 1;
    run_to(20);
    en = 0;
    for (int i = 0; i < 10; i++) begin
      tick(e, r);
      if ({r, de, hs, vs, nf, rgb} !== {5'b00110, 24'h0}) begin
        bad++; $display("FAIL enable_low%0d: got %h want %h", i, {r, de, hs, vs, nf, rgb}, {5'b00110, 24'h0});
      end
    end
    tests++; if (bad != 0) fails++;
    en = 1;
    data = 24'h5A5A5A;
    tick(e, r);
    tests++;
    if ({r, de, rgb} !== {2'b11, 24'h5A5A5A}) begin
      fails++; $display("FAIL enable_resume: got %h want %h", {r, de, rgb}, {2'b11, 24'h5A5A5A});
    end
  endtask

  task automatic test_blank_hold();
    exp_t e; logic r;
    int bad = 0;
    valid = 1;
    run_to(4);
    data = 24'hABCDEF;
    for (int i = 0; i < 4; i++) begin
      tick(e, r);
      if ({r, de} !== 2'b00) begin
        bad++; $display("FAIL blank_hold%0d: got ready/de %b want 00", i, {r, de});
      end
    end
    tests++; if (bad != 0) fails++;
    tick(e, r);
    tests++;
    if ({r, rgb} !== {1'b1, 24'hABCDEF}) begin
      fails++; $display("FAIL blank_accept: got %h want %h", {r, rgb}, {1'b1, 24'hABCDEF});
    end
  endtask

  task automatic test_random();
    exp_t e; logic r;
    int bad = 0;
    inc_mode = 0;
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      en    = ($urandom_range(0, 99) < 95);
      valid = ($urandom_range(0, 99) < 75);
      clr   = ($urandom_range(0, 99) < 5);
      tick(e, r);
      if (obs(r) !== e) begin
        bad++; $display("FAIL random_cycle%0d: got %h want %h", i, obs(r), e);
      end
    end
    rst = 0; en = 1; clr = 0;
    tests++; if (bad != 0) fails++;
  endtask

  initial begin
    rst = 1; en = 0; valid = 0; clr = 0; data = '0;
    test_reset();
    test_stream();
    test_sync();
    test_underflow();
    test_reset_mid();
    test_enable();
    test_blank_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_timing_output.md
Name: video_timing_output

Overview:
- Downstream consumer of the pixel_generator stream (24-bit RGB, valid/ready).
- Generates raster timing (hsync/vsync/data-enable) and pulls exactly one pixel per active-video cycle.
- Drives registered RGB to the display PHY.
- Pulses a frame-restart strobe back to pixel_generator's in_next_frame at the start of vertical blanking.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync width (cycles)
H_BACK, 48, horizontal back porch (cycles)
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0, idle 1

Ports:
in_clk  input  1  pixel clock
in_reset  input  1  synchronous, active-high reset
in_enable  input  1  0 = hold raster at origin, outputs idle
in_pixel_data  input  24  RGB888 from pixel_generator
in_pixel_valid  input  1  upstream pixel valid
in_pixel_ready  output  1  pixel accepted this cycle when valid && ready
in_clear_underflow  input  1  clears sticky underflow flag
out_next_frame  output  1  one-cycle strobe to pixel_generator
out_rgb  output  24  registered pixel to display
out_de  output  1  registered data enable
out_hsync  output  1  registered hsync
out_vsync  output  1  registered vsync
out_underflow  output  1  sticky underflow flag
out_underflow_count  output  16  saturating underflow pixel count

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Counter widths are clog2(total).
- Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1:
  - h_cnt increments each enabled cycle and wraps to 0.
  - v_cnt increments when h_cnt wraps; it wraps to 0 after V_TOTAL-1.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- in_pixel_ready = active && in_enable && !in_reset. It is combinational from the registered counters and does not depend on in_pixel_valid.
- hsync_raw is asserted for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC. vsync_raw uses the same rule on v_cnt. The output level is inverted when SYNC_ACTIVE_LOW=1.
- Output stage has 1-cycle latency. out_rgb, out_de, out_hsync and out_vsync are registered together, so they describe the counter position of the previous cycle and stay mutually aligned.
- active && in_pixel_valid: out_rgb = in_pixel_data, out_de = 1.
- Underflow (active && !in_pixel_valid):
  - out_rgb = 0 and out_de = 1; the raster never stalls.
  - out_underflow is set. It stays set until in_clear_underflow is high.
  - If set and clear occur in the same cycle, set wins.
- Blanking (!active): out_rgb = 0, out_de = 0. Valid is ignored and no pixel is consumed.
- out_next_frame is high for exactly one cycle, when h_cnt==0 && v_cnt==V_ACTIVE (registered, aligned with outputs). This gives pixel_generator the whole vertical blank to restart. No strobe is issued while in_enable is low.
- in_enable low:
  - Counters are held at 0,0.
  - out_de=0, out_rgb=0, syncs at idle level, ready=0.
  - On re-enable the raster starts at 0,0 on the next cycle.
- Reset (asserted at any time, including mid-line):
  - Next edge: counters 0, out_rgb 0, out_de 0, out_hsync/out_vsync at idle level (1 if SYNC_ACTIVE_LOW), out_next_frame 0, out_underflow 0, out_underflow_count 0.
  - in_pixel_ready is 0 while in_reset is high.
  - The first active cycle is immediately after release (if enabled).
- Parameter legality: all values >= 1. Violations are a compile-time error via an elaboration-time check.

Optional Feature:
- VIDEO_UNDERFLOW_COUNT_EN defined: out_underflow_count counts underflow pixels.
  - Saturates at 16'hFFFF.
  - Cleared by reset or in_clear_underflow.
  - Same-cycle clear+underflow yields 1.
- Not defined: out_underflow_count is tied to 0 and no counter logic is built. The sticky flag is unaffected.

Decomposition:
- Package video_pkg holds:
  - typedef rgb888_t (24-bit packed r/g/b).
  - Default 640x480@60 timing constants.
  - Function sync_level(raw, active_low).
- Natural sub-module: raster_counter, holding h/v counters, wrap logic, active/hsync_raw/vsync_raw/frame_start decode. video_timing_output adds handshake, output registers and underflow tracking.

Test Plan:
- Test parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), SYNC_ACTIVE_LOW=1.
- Reset then in_enable=1, valid held 1 with incrementing data 0x000001.. -> exactly 12 handshakes per frame. out_de high 4 cycles of every 8 on lines 0-2. out_rgb 0x000001..0x00000C, each one cycle after its handshake.
- Sync timing -> out_hsync=0 on h_cnt 5,6 (visible one cycle later), out_vsync=0 for all 8 cycles of line 4. out_next_frame high exactly once per 48 cycles, at output of h0/v3.
- valid dropped for 2 active cycles mid-line 1 -> out_rgb=0 with out_de=1 for those 2 outputs, out_underflow=1. out_underflow_count=2 (with the macro defined), 0 without. Pulse in_clear_underflow -> both return to 0.
- Reset asserted at h_cnt=2, v_cnt=1 for one cycle -> next cycle all outputs at reset values, ready=0. After release the raster restarts at 0,0 and ready=1.
- in_enable low for 10 cycles mid-frame -> ready=0, out_de=0, syncs idle, no out_next_frame. On re-enable the first handshake occurs on the next cycle at position 0,0.
- valid=1 during blanking with ready=0 -> upstream data held, not consumed; the first active cycle accepts that same pixel.
